// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART constants and the rounded baud divisor helper
//                used by the baud generator, uart_rx and uart_tx.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_CLK_FREQ_HZ = 25_000_000;
    localparam int UART_BAUD_RATE   = 9600;

    // Number of system clocks per bit, rounded to the nearest integer.
    function automatic int baud_divisor(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/baud_rate_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : baud_rate_clk_gen
//  Description : Gated baud-rate tick generator for the UART receive path.
//                While en is high a counter runs modulo DIVISOR and baud_clk
//                is high for the upper part of each period, so the first rise
//                lands half a bit after enable (bit centre) and subsequent
//                rises follow every full bit period.
//  Ports       : clk      - system clock, all state on rising edge
//                rst      - asynchronous active-high reset
//                en       - run enable; low clears the generator
//                baud_clk - registered baud tick (level, not a clock net)
//  Revision    : 1.0  initial release
// ============================================================================
module baud_rate_clk_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = UART_CLK_FREQ_HZ,
    parameter int BAUD_RATE   = UART_BAUD_RATE
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic baud_clk
);

    localparam int DIVISOR = baud_divisor(CLK_FREQ_HZ, BAUD_RATE);
    localparam int HALF    = DIVISOR / 2;
    localparam int CNT_W   = $clog2(DIVISOR);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] c_HALF    = CNT_W'(HALF);

    generate
        if (DIVISOR < 2) begin : g_divisor_check
            $error("baud_rate_clk_gen: DIVISOR must be at least 2");
        end
    endgenerate

    logic [CNT_W-1:0] r_cnt;
    logic             r_baud_clk;
    logic [CNT_W-1:0] w_cnt_next;

    // Wrap at DIVISOR-1; the wrap is also the falling edge of baud_clk.
    assign w_cnt_next = (r_cnt == c_CNT_MAX) ? '0 : r_cnt + 1'b1;

    // Output is decoded from the next count so baud_clk comes straight off a
    // flop with no input-to-output combinational path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_baud_clk <= 1'b0;
        end else if (en) begin
            r_cnt      <= w_cnt_next;
            r_baud_clk <= (w_cnt_next >= c_HALF);
        end else begin
            // Dropping en aborts the period so re-enable restarts phase at 0.
            r_cnt      <= '0;
            r_baud_clk <= 1'b0;
        end
    end

    assign baud_clk = r_baud_clk;

`ifndef SYNTHESIS
    a_idle_clears : assert property (@(posedge clk) disable iff (rst)
        !en |=> !baud_clk);
`endif

endmodule : baud_rate_clk_gen
`default_nettype wire

// File: tb/tb_baud_rate_clk_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_baud_rate_clk_gen
//  Description : Self-checking bench for baud_rate_clk_gen. Three instances
//                (default 2604, even 10, odd 7 divisors) share clk/rst/en.
//                The reference counts consecutive enabled edges k and expects
//                cnt = k mod D and baud_clk = (k mod D) >= D/2.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_baud_rate_clk_gen;

    localparam int D_DEF = 2604, H_DEF = 1302;
    localparam int D_SM  = 10,   H_SM  = 5;
    localparam int D_OD  = 7,    H_OD  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic bc_def, bc_sm, bc_od;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // Consecutive enabled edges since the last idle edge or reset.
    int k_def = 0, k_sm = 0, k_od = 0;

    always #5 clk = ~clk;

    baud_rate_clk_gen u_def (
        .clk(clk), .rst(rst), .en(en), .baud_clk(bc_def)
    );
    baud_rate_clk_gen #(.CLK_FREQ_HZ(100), .BAUD_RATE(10)) u_sm (
        .clk(clk), .rst(rst), .en(en), .baud_clk(bc_sm)
    );
    baud_rate_clk_gen #(.CLK_FREQ_HZ(70), .BAUD_RATE(10)) u_od (
        .clk(clk), .rst(rst), .en(en), .baud_clk(bc_od)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: edge counter per configuration.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            k_def = 0; k_sm = 0; k_od = 0;
        end else if (en) begin
            k_def++; k_sm++; k_od++;
        end else begin
            k_def = 0; k_sm = 0; k_od = 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_on) begin
            check("def_baud", int'(bc_def), int'((k_def % D_DEF) >= H_DEF));
            check("def_cnt",  int'(u_def.r_cnt), k_def % D_DEF);
            check("sm_baud",  int'(bc_sm),  int'((k_sm % D_SM) >= H_SM));
            check("sm_cnt",   int'(u_sm.r_cnt), k_sm % D_SM);
            check("od_baud",  int'(bc_od),  int'((k_od % D_OD) >= H_OD));
            check("od_cnt",   int'(u_od.r_cnt), k_od % D_OD);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        chk_on = 1'b1;
        check("lit_reset_def_baud", int'(bc_def), 0);
        check("lit_reset_sm_cnt", int'(u_sm.r_cnt), 0);
        cycles(1);

        // Small configs: first rises and the odd-divisor wrap.
        en = 1'b1;
        cycles(4);                                   // after edge 4
        check("lit_sm_k4", int'(bc_sm), 0);
        check("lit_od_k4", int'(bc_od), 1);
        cycles(1);                                   // edge 5
        check("lit_sm_k5", int'(bc_sm), 1);
        cycles(2);                                   // edge 7
        check("lit_sm_k7", int'(bc_sm), 1);
        check("lit_od_k7", int'(bc_od), 0);

        // Abort mid-period, then restart: next rise 5 edges after re-enable.
        en = 1'b0;
        cycles(1);
        check("lit_abort_baud", int'(bc_sm), 0);
        check("lit_abort_cnt", int'(u_sm.r_cnt), 0);
        en = 1'b1;
        cycles(4);
        check("lit_restart_k4", int'(bc_sm), 0);
        cycles(1);
        check("lit_restart_k5", int'(bc_sm), 1);

        // Default divisor: rise after edge 1302, fall after edge 2604.
        en = 1'b0;
        cycles(1);
        en = 1'b1;
        cycles(1301);
        check("lit_def_k1301", int'(bc_def), 0);
        cycles(1);
        check("lit_def_k1302", int'(bc_def), 1);
        cycles(1301);
        check("lit_def_k2603", int'(bc_def), 1);
        cycles(1);
        check("lit_def_k2604", int'(bc_def), 0);
        check("lit_sm_k2604", int'(bc_sm), 0);    // 2604 mod 10 = 4

        // Asynchronous reset mid-count takes effect without a clk edge.
        cycles(1400);
        #2 rst = 1'b1;
        #1;
        check("lit_async_def_baud", int'(bc_def), 0);
        check("lit_async_def_cnt", int'(u_def.r_cnt), 0);
        cycles(5);
        check("lit_rst_hold_cnt", int'(u_def.r_cnt), 0);
        rst = 1'b0;

        // Long idle, then isolated one-cycle enable pulses.
        en = 1'b0;
        cycles(1000);
        for (int i = 0; i < 20; i++) begin
            en = 1'b1;
            cycles(1);
            check("lit_pulse_cnt", int'(u_sm.r_cnt), 1);
            en = 1'b0;
            cycles($urandom_range(1, 5));
            check("lit_pulse_baud", int'(bc_sm), 0);
        end

        // Randomized enable with occasional asynchronous reset pulses.
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end else begin
                en = ($urandom_range(0, 19) != 0);
                @(negedge clk);
            end
        end

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_baud_rate_clk_gen
`default_nettype wire
